// File: rtl/gcn_aggregation_block.sv
// GCN aggregation stage: sums each node's FM*WM row with its COO neighbours' rows
// (self-loop included) and reports the per-node argmax class index.
module gcn_aggregation_block #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int NUM_EDGES         = 6,
    parameter int COO_WIDTH         = 3,
    parameter int COO_ADDRESS_WIDTH = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int MAX_ADDRESS_WIDTH = 2
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    output logic [COO_ADDRESS_WIDTH-1:0]                       coo_address,
    input  logic [0:1][COO_WIDTH-1:0]                          coo_in,
    output logic [2:0]                                         read_row,
    input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]         fm_wm_row_in,
    output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]     max_addi_answer,
    output logic                                               done
);

    localparam int ROW_W = 3;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
    localparam logic [COO_ADDRESS_WIDTH-1:0] LAST_EDGE = COO_ADDRESS_WIDTH'(NUM_EDGES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELF, S_FETCH, S_ADD_A, S_ADD_B, S_ARGMAX, S_DONE
    } state_t;

    typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] row_t;

    state_t                                       r_state;
    state_t                                       w_state_next;
    logic [ROW_W-1:0]                             r_n;
    logic [COO_ADDRESS_WIDTH-1:0]                 r_e;
    logic [COO_WIDTH-1:0]                         r_src;
    logic [COO_WIDTH-1:0]                         r_dst;
    row_t                                         r_agg [FEATURE_ROWS];
    logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] r_ans;

    logic [ROW_W-1:0]             w_read_row;
    logic [COO_ADDRESS_WIDTH-1:0] w_coo_address;
    logic                         w_self_edge;
    logic                         w_last_edge;
    logic                         w_edge_ok;
    row_t                         w_cur_row;
    logic [DOT_PROD_WIDTH-1:0]    w_best_val;
    logic [MAX_ADDRESS_WIDTH-1:0] w_best_idx;

    assign w_self_edge = (r_src == r_dst);
    assign w_last_edge = (r_e == LAST_EDGE);
    // An edge naming a node outside the graph is consumed but contributes nothing.
    assign w_edge_ok   = ({1'b0, r_src} < (COO_WIDTH+1)'(FEATURE_ROWS)) &&
                         ({1'b0, r_dst} < (COO_WIDTH+1)'(FEATURE_ROWS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_read_row    = '0;
        w_coo_address = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_SELF;
            end
            S_SELF: begin
                w_read_row = r_n;
                if (r_n == LAST_ROW) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_coo_address = r_e;
                w_state_next  = S_ADD_A;
            end
            S_ADD_A: begin
                w_read_row = ROW_W'(r_src);
                if (!w_self_edge)     w_state_next = S_ADD_B;
                else if (w_last_edge) w_state_next = S_ARGMAX;
                else                  w_state_next = S_FETCH;
            end
            S_ADD_B: begin
                w_read_row   = ROW_W'(r_dst);
                w_state_next = w_last_edge ? S_ARGMAX : S_FETCH;
            end
            S_ARGMAX: begin
                if (r_n == LAST_ROW) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (!start) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n   <= '0;
            r_e   <= '0;
            r_src <= '0;
            r_dst <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_n <= '0;
                    r_e <= '0;
                end
                S_SELF:   r_n <= (r_n == LAST_ROW) ? '0 : r_n + 1'b1;
                S_FETCH: begin
                    r_src <= coo_in[0];
                    r_dst <= coo_in[1];
                end
                S_ADD_A:  if (w_self_edge && !w_last_edge) r_e <= r_e + 1'b1;
                S_ADD_B:  if (!w_last_edge) r_e <= r_e + 1'b1;
                S_ARGMAX: r_n <= r_n + 1'b1;
                default: ;
            endcase
        end
    end

    // One accumulator row per node; ADD_A feeds dst from src's row, ADD_B the reverse.
    generate
        for (genvar gi = 0; gi < FEATURE_ROWS; gi++) begin : g_agg
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_agg[gi] <= '0;
                end else if (r_state == S_SELF && r_n == ROW_W'(gi)) begin
                    r_agg[gi] <= fm_wm_row_in;
                end else if (w_edge_ok &&
                             ((r_state == S_ADD_A && r_dst == COO_WIDTH'(gi)) ||
                              (r_state == S_ADD_B && r_src == COO_WIDTH'(gi)))) begin
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        r_agg[gi][c] <= r_agg[gi][c] + fm_wm_row_in[c];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_cur_row = '0;
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (r_n == ROW_W'(i)) w_cur_row = r_agg[i];
        end
        // Strict compare keeps the lowest column on ties.
        w_best_val = w_cur_row[0];
        w_best_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (w_cur_row[c] > w_best_val) begin
                w_best_val = w_cur_row[c];
                w_best_idx = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ans <= '0;
        end else if (r_state == S_ARGMAX) begin
            for (int i = 0; i < FEATURE_ROWS; i++) begin
                if (r_n == ROW_W'(i)) r_ans[i] <= w_best_idx;
            end
        end
    end

    assign read_row        = w_read_row;
    assign coo_address     = w_coo_address;
    assign max_addi_answer = r_ans;
    assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_gcn_aggregation_block.sv
// Scoreboard bench for gcn_aggregation_block: runs are queued with hand-computed
// answers and latency; a monitor checks them when done rises.
module tb_gcn_aggregation_block;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [2:0]             coo_address;
    logic [0:1][2:0]        coo_in;
    logic [2:0]             read_row;
    logic [0:2][15:0]       fm_wm_row_in;
    logic [0:5][1:0]        max_addi_answer;
    logic                   done;

    typedef struct packed {
        logic [0:5][1:0] ans;
        int              lat;
    } exp_t;

    exp_t            exp_q [$];
    logic [0:2][15:0] row_mem [8];
    logic [0:1][2:0]  coo_mem [8];
    int              n_chk  = 0;
    int              n_fail = 0;
    int              cyc    = 0;
    int              start_cyc = 0;
    logic            prev_done = 1'b0;

    gcn_aggregation_block dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .coo_address     (coo_address),
        .coo_in          (coo_in),
        .read_row        (read_row),
        .fm_wm_row_in    (fm_wm_row_in),
        .max_addi_answer (max_addi_answer),
        .done            (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fm_wm_row_in = row_mem[read_row];
    assign coo_in       = coo_mem[coo_address];

    task automatic check(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    // Monitor: each rising done consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 6; i++) begin
                    check($sformatf("answer[%0d]", i), int'(max_addi_answer[i]), int'(e.ans[i]));
                end
                check("latency", cyc - start_cyc, e.lat);
            end
        end
        prev_done = done;
    end

    task automatic set_edge(input int i, input int s, input int d);
        coo_mem[i][0] = 3'(s);
        coo_mem[i][1] = 3'(d);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) begin
            // Rows 6/7 are never legitimately read; nonzero data exposes a missed drop.
            row_mem[i] = (i >= 6) ? {16'd0, 16'd0, 16'd9} : '0;
            coo_mem[i] = '0;
        end
    endtask

    task automatic load_ring();
        clear_mem();
        for (int i = 0; i < 6; i++) begin
            row_mem[i] = {16'(i), 16'd0, 16'd0};
            set_edge(i, i, (i + 1) % 6);
        end
    endtask

    task automatic load_tie();
        clear_mem();
        row_mem[0] = {16'd1, 16'd9, 16'd2};
        row_mem[1] = {16'd5, 16'd0, 16'd7};
        set_edge(0, 0, 1);
        for (int i = 1; i < 6; i++) set_edge(i, 2, 2);
    endtask

    task automatic load_wrap();
        clear_mem();
        row_mem[0] = {16'd5, 16'd0, 16'd1};
        row_mem[1] = {16'd0, 16'd0, 16'hFFFF};
        row_mem[2] = {16'd0, 16'd4, 16'd1};
        row_mem[3] = {16'd0, 16'd7, 16'd0};
        set_edge(0, 1, 0);
        set_edge(1, 2, 0);
        set_edge(2, 7, 1);
        for (int i = 3; i < 6; i++) set_edge(i, 3, 3);
    endtask

    task automatic run(input logic [0:5][1:0] ans, input int lat, input int hold);
        exp_t e;
        e.ans = ans;
        e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) check("run_timeout", 0, 1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_done_high", int'(done), 1);
            check("hold_read_row", int'(read_row), 0);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_drop", int'(done), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_answers", int'(max_addi_answer), 0);
        check("reset_read_row", int'(read_row), 0);
        check("reset_coo_address", int'(coo_address), 0);

        load_ring();
        run({2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 31, 0);

        load_tie();
        run({2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 26, 0);

        load_wrap();
        run({2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, 28, 0);

        // Abort during the edge phase; answers from the tie run must be wiped.
        load_tie();
        run({2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 26, 0);
        @(negedge clk);
        start = 1'b1;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", int'(done), 0);
        check("abort_answers", int'(max_addi_answer), 0);
        check("abort_read_row", int'(read_row), 0);
        load_wrap();
        run({2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, 28, 0);

        // start held across DONE must not restart; a fresh edge reruns identically.
        load_tie();
        run({2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 26, 10);
        run({2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, 26, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
